id_issue_ctrl: RTL and testbench
================================

Name: id_issue_ctrl

Overview:
Issue controller for the decode stage of the MVP core. It sits between instruction fetch (IF) and the ID/EX boundary. It accepts instructions over a valid/ready handshake and decodes operand usage. A 16-entry register scoreboard blocks RAW/WAW hazards against writes still in flight to WB. On a jump it sequences a flush and waits for resolution before issuing again.

Parameters:
NUM_REGS, 16, architectural registers; scoreboard width (address width fixed at 4).
MAX_INFLIGHT, 4, max issued instructions not yet retired; 1..7.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  IF offers instruction
in_instr  in  16  instruction word
in_ready  out  1  instruction accepted when in_valid && in_ready
out_valid  out  1  issued instruction held for EX
out_ready  in  1  EX accepts issued instruction
out_instr  out  16  issued instruction word
out_opcode  out  5  issued opcode
out_rd_addr  out  4  field rd
out_rs_addr  out  4  field rs
out_reg_write  out  1  issued instruction writes rd
WB_reg_write  in  1  writeback of WB_reg_addr this cycle
WB_reg_addr  in  4  writeback register
retire  in  1  one instruction left the pipe (writes or not)
jmp_done  in  1  EX resolved the outstanding jump
flush  out  1  one-cycle pulse to IF: discard fetched stream
stall  out  1  hazard or in-flight limit blocks a valid instruction
illegal  out  1  one-cycle pulse: accepted opcode 01010..11111

Behaviour:
- Encoding: [15:11] opcode, [10:7] rd, [6:3] rs, [2:0] unused.
- Reads/writes per opcode:
  - MOV/LD/NOT: read rs, write rd.
  - ADD/SUB/AND/OR: read rd and rs, write rd.
  - ST: read rd and rs, no write.
  - JMP: read rs, no write.
  - NOP: no reads, no writes.
  - Illegal opcodes: issued as NOP (out_opcode=01001, out_reg_write=0); illegal pulses.
- Reset (reset=0, async): state=RUN, scoreboard=0, inflight=0. All outputs 0; out_instr=0.
- Hazard (combinational, from registered scoreboard only): hazard = any read reg pending, OR (writes && rd pending). No bypass from WB in the same cycle.
- slot_free = !out_valid || out_ready.
- RUN: issue = in_valid && slot_free && !hazard && inflight<MAX_INFLIGHT.
  - in_ready = issue.
  - stall = in_valid && !issue && slot_free.
- Issue (1-cycle latency): next edge loads out_* and sets out_valid=1. If writes, sets scoreboard[rd]. inflight+1.
- out_valid clears on out_ready with no new issue.
- Scoreboard clear: WB_reg_write clears bit WB_reg_addr, ignored if the bit is already 0. Set and clear of the same bit in one cycle cannot occur (WAW stall). If it does, set wins.
- inflight: +1 on issue, −1 on retire, both → unchanged. retire at 0 is ignored (saturates).
- JMP issue: flush=1 next cycle; state → JWAIT.
- JWAIT: in_ready=1 and accepted instructions are discarded (no issue, no scoreboard change); stall=0. On jmp_done → RUN, effective next cycle.
- jmp_done in RUN is ignored.
- out_ready is ignored while out_valid=0.
- out_* are stable while out_valid && !out_ready.

Decomposition:
- Shared package isa_pkg: opcode constants (op_MOV..op_NOP, 5-bit) and field bit positions.
- Decode-usage function: reads_rd, reads_rs, writes_rd, is_jmp, is_illegal.
- Optional sub-module id_scoreboard: 16-bit set/clear/lookup with two read checks.
- FSM and handshake stay in top.

Test Plan:
- ADD r1,r2 (0x1890) then SUB r3,r1 (0x2188), no WB: first issues next cycle with out_reg_write=1; second stalls (stall=1, in_ready=0). WB_reg_write=1, WB_reg_addr=1 → SUB issues the following cycle.
- JMP r5 (0x4028) then 0x1890 offered continuously: flush=1 one cycle after JMP issue. The ADD is accepted and discarded, with no out_valid for it. After jmp_done, the next 0x1890 issues.
- Back-to-back NOP (0x4800), out_ready=1: issue every cycle; inflight reaches 4 without retire → stall=1. One retire → one more issue.
- out_ready=0 with 0x1890 issued and 0x4800 pending: out_instr stays 0x1890, in_ready=0, stall=0. Releasing out_ready issues the NOP.
- 0xF800: illegal pulses one cycle; out_opcode=01001, out_reg_write=0.
- reset=0 asserted mid-JWAIT with scoreboard[1] set: all outputs 0 immediately. After release, 0x2188 issues without stall.

Source files
------------

// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg
// Shared ISA definitions for the decode stage of the MVP core.
//   - 16-bit instruction layout: [15:11] opcode, [10:7] rd, [6:3] rs, [2:0] unused
//   - 5-bit opcode constants op_MOV..op_NOP (10..31 are illegal)
//   - Issue-controller FSM state type
//   - decode_usage(): register read/write usage of an opcode
// ---------------------------------------------------------------------------
package isa_pkg;

    // Instruction field bit positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;
    localparam int RD_HI  = 10;
    localparam int RD_LO  = 7;
    localparam int RS_HI  = 6;
    localparam int RS_LO  = 3;

    // Opcode constants
    localparam logic [4:0] op_MOV = 5'd0;
    localparam logic [4:0] op_LD  = 5'd1;
    localparam logic [4:0] op_ST  = 5'd2;
    localparam logic [4:0] op_ADD = 5'd3;
    localparam logic [4:0] op_SUB = 5'd4;
    localparam logic [4:0] op_AND = 5'd5;
    localparam logic [4:0] op_OR  = 5'd6;
    localparam logic [4:0] op_NOT = 5'd7;
    localparam logic [4:0] op_JMP = 5'd8;
    localparam logic [4:0] op_NOP = 5'd9;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_JWAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic reads_rd;
        logic reads_rs;
        logic writes_rd;
        logic is_jmp;
        logic is_illegal;
    } usage_t;

    // Operand usage of an opcode. Illegal opcodes report no register use so
    // they flow through the issue logic exactly like a NOP.
    function automatic usage_t decode_usage(input logic [4:0] opc);
        usage_t u;
        u = '0;
        case (opc)
            op_MOV, op_LD, op_NOT: begin
                u.reads_rs  = 1'b1;
                u.writes_rd = 1'b1;
            end
            op_ADD, op_SUB, op_AND, op_OR: begin
                u.reads_rd  = 1'b1;
                u.reads_rs  = 1'b1;
                u.writes_rd = 1'b1;
            end
            op_ST: begin
                u.reads_rd = 1'b1;
                u.reads_rs = 1'b1;
            end
            op_JMP: begin
                u.reads_rs = 1'b1;
                u.is_jmp   = 1'b1;
            end
            op_NOP: begin
                u = '0;
            end
            default: begin
                u.is_illegal = 1'b1;
            end
        endcase
        return u;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// ---------------------------------------------------------------------------
// id_scoreboard
// Pending-write bitmap: one bit per architectural register, set when an
// instruction that writes the register issues, cleared on writeback.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   set_en/set_addr     mark register pending (wins over a same-bit clear)
//   clr_en/clr_addr     writeback clears the register's pending bit
//   chk_a/b_addr        two lookup addresses
//   pend_a/pend_b       registered pending state of those addresses
// ---------------------------------------------------------------------------
module id_scoreboard #(
    parameter int NUM_REGS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en,
    input  logic [3:0] set_addr,
    input  logic       clr_en,
    input  logic [3:0] clr_addr,
    input  logic [3:0] chk_a_addr,
    input  logic [3:0] chk_b_addr,
    output logic       pend_a,
    output logic       pend_b
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_mask
            assign set_mask[gi] = set_en && (set_addr == 4'(gi));
            assign clr_mask[gi] = clr_en && (clr_addr == 4'(gi));
        end
    endgenerate

    // Clear first, then set, so a same-cycle set of the same bit survives.
    always_comb begin
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Lookups use registered state only: no same-cycle bypass from writeback.
    assign pend_a = pend_q[chk_a_addr];
    assign pend_b = pend_q[chk_b_addr];

endmodule

// File: rtl/id_issue_ctrl.sv
// ---------------------------------------------------------------------------
// id_issue_ctrl
// Decode-stage issue controller between IF and the ID/EX boundary.
// Accepts instructions over valid/ready, blocks RAW/WAW hazards with a
// register scoreboard, limits instructions in flight, and sequences a flush
// plus wait-for-resolution on every jump.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr instruction stream from IF
//   out_valid/out_ready        issued instruction handshake to EX
//   out_instr/out_opcode/out_rd_addr/out_rs_addr/out_reg_write  issued fields
//   WB_reg_write/WB_reg_addr   writeback, clears the scoreboard bit
//   retire                     one instruction left the pipe
//   jmp_done                   EX resolved the outstanding jump
//   flush                      one-cycle pulse after a jump issues
//   stall                      valid instruction blocked by hazard/limit
//   illegal                    one-cycle pulse after accepting an illegal opcode
// ---------------------------------------------------------------------------
module id_issue_ctrl
    import isa_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [4:0]  out_opcode,
    output logic [3:0]  out_rd_addr,
    output logic [3:0]  out_rs_addr,
    output logic        out_reg_write,
    input  logic        WB_reg_write,
    input  logic [3:0]  WB_reg_addr,
    input  logic        retire,
    input  logic        jmp_done,
    output logic        flush,
    output logic        stall,
    output logic        illegal
);

    localparam int CNT_W = 3;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_instr_q, out_instr_d;
    logic [4:0]        out_opcode_q, out_opcode_d;
    logic [3:0]        out_rd_q, out_rd_d;
    logic [3:0]        out_rs_q, out_rs_d;
    logic              out_reg_write_q, out_reg_write_d;
    logic              flush_q, flush_d;
    logic              illegal_q, illegal_d;

    logic [4:0] in_opc;
    logic [3:0] in_rd;
    logic [3:0] in_rs;
    usage_t     in_use;
    logic       pend_rd;
    logic       pend_rs;
    logic       hazard;
    logic       slot_free;
    logic       below_limit;
    logic       issue;
    logic       in_ready_s;
    logic       stall_s;
    logic       accept;

    assign in_opc = in_instr[OPC_HI:OPC_LO];
    assign in_rd  = in_instr[RD_HI:RD_LO];
    assign in_rs  = in_instr[RS_HI:RS_LO];
    assign in_use = decode_usage(in_opc);

    id_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (issue && in_use.writes_rd),
        .set_addr   (in_rd),
        .clr_en     (WB_reg_write),
        .clr_addr   (WB_reg_addr),
        .chk_a_addr (in_rd),
        .chk_b_addr (in_rs),
        .pend_a     (pend_rd),
        .pend_b     (pend_rs)
    );

    // A pending rd blocks both reads of rd (RAW) and writes of rd (WAW).
    assign hazard      = (in_use.reads_rd && pend_rd) ||
                         (in_use.reads_rs && pend_rs) ||
                         (in_use.writes_rd && pend_rd);
    assign slot_free   = !out_valid_q || out_ready;
    assign below_limit = inflight_q < CNT_W'(MAX_INFLIGHT);

    // FSM: next state and handshake decisions
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        in_ready_s = 1'b0;
        stall_s    = 1'b0;
        case (state_q)
            ST_RUN: begin
                issue      = in_valid && slot_free && !hazard && below_limit;
                in_ready_s = issue;
                stall_s    = in_valid && !issue && slot_free;
                if (issue && in_use.is_jmp) begin
                    state_d = ST_JWAIT;
                end
            end
            ST_JWAIT: begin
                // Drain the wrong-path stream: accept and drop everything.
                in_ready_s = 1'b1;
                if (jmp_done) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign accept = in_valid && in_ready_s;

    // Datapath next values
    always_comb begin
        out_valid_d     = out_valid_q;
        out_instr_d     = out_instr_q;
        out_opcode_d    = out_opcode_q;
        out_rd_d        = out_rd_q;
        out_rs_d        = out_rs_q;
        out_reg_write_d = out_reg_write_q;
        inflight_d      = inflight_q;
        flush_d         = issue && in_use.is_jmp;
        illegal_d       = accept && in_use.is_illegal;

        if (issue) begin
            out_valid_d     = 1'b1;
            out_instr_d     = in_instr;
            out_opcode_d    = in_use.is_illegal ? op_NOP : in_opc;
            out_rd_d        = in_rd;
            out_rs_d        = in_rs;
            out_reg_write_d = in_use.writes_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Issue and retire together cancel; retire at zero saturates.
        if (issue && !retire) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue && retire && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_RUN;
            inflight_q      <= '0;
            out_valid_q     <= 1'b0;
            out_instr_q     <= '0;
            out_opcode_q    <= '0;
            out_rd_q        <= '0;
            out_rs_q        <= '0;
            out_reg_write_q <= 1'b0;
            flush_q         <= 1'b0;
            illegal_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= inflight_d;
            out_valid_q     <= out_valid_d;
            out_instr_q     <= out_instr_d;
            out_opcode_q    <= out_opcode_d;
            out_rd_q        <= out_rd_d;
            out_rs_q        <= out_rs_d;
            out_reg_write_q <= out_reg_write_d;
            flush_q         <= flush_d;
            illegal_q       <= illegal_d;
        end
    end

    // Combinational handshake outputs are forced low while reset is held so
    // every output reads 0 during reset regardless of in_valid.
    assign in_ready      = in_ready_s && reset;
    assign stall         = stall_s && reset;
    assign out_valid     = out_valid_q;
    assign out_instr     = out_instr_q;
    assign out_opcode    = out_opcode_q;
    assign out_rd_addr   = out_rd_q;
    assign out_rs_addr   = out_rs_q;
    assign out_reg_write = out_reg_write_q;
    assign flush         = flush_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
module tb_id_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [4:0]  out_opcode;
    logic [3:0]  out_rd_addr;
    logic [3:0]  out_rs_addr;
    logic        out_reg_write;
    logic        WB_reg_write;
    logic [3:0]  WB_reg_addr;
    logic        retire;
    logic        jmp_done;
    logic        flush;
    logic        stall;
    logic        illegal;

    always #5 clk = ~clk;

    id_issue_ctrl #(
        .NUM_REGS     (16),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_opcode    (out_opcode),
        .out_rd_addr   (out_rd_addr),
        .out_rs_addr   (out_rs_addr),
        .out_reg_write (out_reg_write),
        .WB_reg_write  (WB_reg_write),
        .WB_reg_addr   (WB_reg_addr),
        .retire        (retire),
        .jmp_done      (jmp_done),
        .flush         (flush),
        .stall         (stall),
        .illegal       (illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_pend [16];
    int          m_infl;
    bit          m_jwait;
    bit          m_ov;
    logic [15:0] m_instr;
    logic [4:0]  m_opc;
    logic [3:0]  m_rd;
    logic [3:0]  m_rs;
    bit          m_rw;
    bit          m_flush;
    bit          m_ill;

    // ISA operand table: MOV LD ST ADD SUB AND OR NOT JMP NOP = 0..9
    task automatic usage(input int op, output bit rrd, output bit rrs,
                         output bit wrd, output bit jmp, output bit ill);
        rrd = 0; rrs = 0; wrd = 0; jmp = 0; ill = 0;
        case (op)
            0, 1, 7:    begin rrs = 1; wrd = 1; end
            3, 4, 5, 6: begin rrd = 1; rrs = 1; wrd = 1; end
            2:          begin rrd = 1; rrs = 1; end
            8:          begin rrs = 1; jmp = 1; end
            9:          ;
            default:    ill = 1;
        endcase
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_infl = 0; m_jwait = 0; m_ov = 0;
        m_instr = '0; m_opc = '0; m_rd = '0; m_rs = '0; m_rw = 0;
        m_flush = 0; m_ill = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},  in_ready, 0);
        chk({tag, "_stall"},     stall, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_instr"}, out_instr, 0);
        chk({tag, "_opcode"},    out_opcode, 0);
        chk({tag, "_rd"},        out_rd_addr, 0);
        chk({tag, "_rs"},        out_rs_addr, 0);
        chk({tag, "_reg_write"}, out_reg_write, 0);
        chk({tag, "_flush"},     flush, 0);
        chk({tag, "_illegal"},   illegal, 0);
    endtask

    // One clock: inputs already applied after a negedge.
    task automatic step();
        bit rrd, rrs, wrd, jmp, ill, haz, sf, iss, e_rdy, e_stall;
        int op, rd, rs;
        #1;
        op = int'(in_instr[15:11]);
        rd = int'(in_instr[10:7]);
        rs = int'(in_instr[6:3]);
        usage(op, rrd, rrs, wrd, jmp, ill);
        haz = (rrd && m_pend[rd]) || (rrs && m_pend[rs]) || (wrd && m_pend[rd]);
        sf  = !m_ov || out_ready;
        if (m_jwait) begin
            e_rdy = 1; e_stall = 0; iss = 0;
        end else begin
            iss     = in_valid && sf && !haz && (m_infl < 4);
            e_rdy   = iss;
            e_stall = in_valid && !iss && sf;
        end
        chk("in_ready", in_ready, e_rdy);
        chk("stall", stall, e_stall);

        m_flush = iss && jmp;
        m_ill   = in_valid && e_rdy && ill;
        if (m_jwait) m_jwait = !jmp_done;
        else         m_jwait = iss && jmp;
        if (WB_reg_write) m_pend[WB_reg_addr] = 0;
        if (iss && wrd)   m_pend[rd] = 1;
        if (iss && !retire)                   m_infl++;
        else if (!iss && retire && m_infl > 0) m_infl--;
        if (iss) begin
            m_ov = 1; m_instr = in_instr; m_opc = ill ? 5'd9 : 5'(op);
            m_rd = 4'(rd); m_rs = 4'(rs); m_rw = wrd;
        end else if (out_ready) begin
            m_ov = 0;
        end

        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("flush", flush, m_flush);
        chk("illegal", illegal, m_ill);
        if (m_ov) begin
            chk("out_instr", out_instr, m_instr);
            chk("out_opcode", out_opcode, m_opc);
            chk("out_rd", out_rd_addr, m_rd);
            chk("out_rs", out_rs_addr, m_rs);
            chk("out_reg_write", out_reg_write, m_rw);
        end
        if (iss)
            $display("issue instr=0x%04h opcode=%0d rd=%0d rs=%0d inflight=%0d",
                     in_instr, m_opc, rd, rs, m_infl);
    endtask

    task automatic cyc(input bit v, input logic [15:0] ins, input bit ordy,
                       input bit wbw, input logic [3:0] wba, input bit ret, input bit jd);
        @(negedge clk);
        in_valid = v; in_instr = ins; out_ready = ordy;
        WB_reg_write = wbw; WB_reg_addr = wba; retire = ret; jmp_done = jd;
        step();
    endtask

    initial begin
        reset = 0; in_valid = 0; in_instr = '0; out_ready = 0;
        WB_reg_write = 0; WB_reg_addr = '0; retire = 0; jmp_done = 0;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1;

        // RAW stall on r1, released by writeback (no same-cycle bypass)
        cyc(1, 16'h1890, 1, 0, 0, 0, 0);
        chk("tp_add_rw", out_reg_write, 1);
        cyc(1, 16'h2188, 1, 0, 0, 0, 0);
        cyc(1, 16'h2188, 1, 1, 1, 0, 0);
        cyc(1, 16'h2188, 1, 0, 0, 0, 0);
        chk("tp_sub_issued", out_instr, 16'h2188);
        cyc(0, 16'h0000, 1, 1, 3, 1, 0);
        cyc(0, 16'h0000, 1, 0, 0, 1, 0);

        // Jump: flush, discard wrong path, resume after jmp_done
        cyc(1, 16'h4028, 1, 0, 0, 0, 0);
        chk("tp_jmp_flush", flush, 1);
        repeat (3) cyc(1, 16'h1890, 1, 0, 0, 0, 0);
        chk("tp_jwait_no_valid", out_valid, 0);
        cyc(1, 16'h1890, 1, 0, 0, 0, 1);
        cyc(1, 16'h1890, 1, 0, 0, 0, 0);
        chk("tp_after_jmp", out_instr, 16'h1890);
        cyc(0, 16'h0000, 1, 1, 1, 1, 0);
        cyc(0, 16'h0000, 1, 0, 0, 1, 0);

        // In-flight limit with back-to-back NOPs
        repeat (5) cyc(1, 16'h4800, 1, 0, 0, 0, 0);
        chk("tp_limit_stall", stall, 1);
        cyc(1, 16'h4800, 1, 0, 0, 1, 0);
        cyc(1, 16'h4800, 1, 0, 0, 0, 0);
        repeat (4) cyc(0, 16'h0000, 1, 0, 0, 1, 0);

        // Backpressure holds the issued instruction
        cyc(1, 16'h1890, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 16'h4800, 0, 0, 0, 0, 0);
        chk("tp_hold_instr", out_instr, 16'h1890);
        cyc(1, 16'h4800, 1, 0, 0, 0, 0);
        chk("tp_nop_after_release", out_instr, 16'h4800);
        cyc(0, 16'h0000, 1, 1, 1, 1, 0);
        cyc(0, 16'h0000, 1, 0, 0, 1, 0);

        // Illegal opcode issued as NOP
        cyc(1, 16'hF800, 1, 0, 0, 0, 0);
        chk("tp_illegal_opcode", out_opcode, 5'b01001);
        cyc(0, 16'h0000, 1, 0, 0, 1, 0);
        chk("tp_illegal_pulse", illegal, 0);

        // Asynchronous reset in the middle of a jump wait
        cyc(1, 16'h1890, 1, 0, 0, 0, 0);
        cyc(1, 16'h4028, 1, 0, 0, 0, 0);
        cyc(1, 16'h1890, 1, 0, 0, 0, 0);
        #2;
        reset = 0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        in_valid = 0; retire = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        cyc(1, 16'h2188, 1, 0, 0, 0, 0);
        chk("tp_post_reset_issue", out_instr, 16'h2188);
        chk("tp_post_reset_valid", out_valid, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ins;
            logic [4:0]  op;
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(10, 31))
                                             : 5'($urandom_range(0, 9));
            ins = {op, 1'b0, 3'($urandom_range(0, 7)), 1'b0,
                   3'($urandom_range(0, 7)), 3'($urandom)};
            cyc($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)),
                $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
